fifo_serializer: RTL and testbench
==================================

# fifo_serializer

Parametrised word FIFO with an integrated parallel-to-serial output stage, next generation of the team's byte-in/bit-out FIFO. Accepts DATA_W-bit words through a ready/valid port, buffers up to DEPTH words, and emits each word as DATA_W/LANE_W consecutive LANE_W-bit beats with a start-of-word marker. It sits between packet-assembly logic and a serial line driver.

## Interface
- DATA_W, 8: input word width.
- DEPTH, 32: storage depth in words; power of two, ≥ 2.
- LANE_W, 1: bits per output beat; must divide DATA_W.
- MSB_FIRST, 0: 1 sends the most significant lane first; 0 sends the least significant lane first.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_W  write word.
- in_valid  in  1  write request.
- in_ready  out  1  = !full; write accepted when in_valid && in_ready.
- out_en  in  1  permission to start a new word.
- ser_data  out  LANE_W  current beat.
- ser_valid  out  1  ser_data holds a valid beat.
- ser_sof  out  1  high on beat 0 of each word.
- full  out  1  DEPTH words stored.
- empty  out  1  no words stored.
- level  out  $clog2(DEPTH)+1  stored word count, excluding any word in the serializer.

## Operation
- Storage: DEPTH-entry array; rd/wr pointers $clog2(DEPTH)+1 bits with wrap bit; full = pointers equal except the wrap bit; empty = pointers fully equal; natural wrap, no compare against DEPTH-1.
- Push: in_valid && !full → store at wr_ptr, wr_ptr+1. Push while full is ignored; in_ready low.
- Pop (load): serializer reads the head word into the shift register, rd_ptr+1.
- No bypass: a word written on edge t is first poppable on edge t+1.
- Simultaneous push and pop: both take effect; level unchanged. Push while full with a same-cycle pop is still refused.
- BEATS = DATA_W/LANE_W; beat counter $clog2(BEATS) bits (min 1).
- FSM states: IDLE, SHIFT, PAR (PAR only with parity configured).
- IDLE: out_en && !empty → load, beat 0 presented, go SHIFT. Otherwise stay; ser_valid=0, ser_data=0.
- SHIFT: one beat per cycle. On the last beat: go PAR if configured; else if out_en && !empty, load the next word back-to-back with zero gap; else go IDLE.
- PAR: one beat; then same load/IDLE decision as the last SHIFT beat.
- out_en is sampled only at word boundaries; deasserting it mid-word does not truncate the word.
- Lane order per MSB_FIRST; lane k (LSB-first) = word[k*LANE_W +: LANE_W].

## Timing
- Reset values: ser_data=0, ser_valid=0, ser_sof=0, full=0, empty=1, level=0, in_ready=1; FSM=IDLE; pointers 0. Assertion mid-word aborts the word immediately; the word is lost.
- ser_data, ser_valid and ser_sof are registered. A load on edge t presents beat 0 (ser_sof=1) in cycle t+1.
- Per-word duration: BEATS cycles, or BEATS+1 with parity. Sustained throughput: one word per BEATS(+1) cycles.
- full, empty and level are registered and update on the edge of the push/pop. in_ready is combinational from full.

## Configuration
- FIFO_SERIALIZER_PARITY_EN defined: after the last data beat, one extra beat with ser_data = {LANE_W-1 zeros, ^word} (even parity), ser_sof=0.
- Undefined: no PAR state; words are BEATS beats.

## Structure
- Package fifo_serializer_pkg: FSM state enum (ST_IDLE, ST_SHIFT, ST_PAR); function beats(DATA_W, LANE_W); parameter legality checks.
- Sub-module fifo_serializer_buf: storage array, pointers, full/empty/level. Top level holds the FSM and shift register.

## Test plan
- Defaults; push 0xA5, hold out_en=1 → ser_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_sof on the first; then empty=1, ser_valid=0.
- LANE_W=4, MSB_FIRST=1; push 0x3C, 0x81, out_en=1 → beats 3,C,8,1 with no gap; ser_sof on beats 0 and 2.
- Push 32 words without reading → full=1, level=32, in_ready=0; a 33rd push is dropped. Drain all → data intact, in order across the pointer wrap.
- out_en pulsed for 1 cycle mid-stream → the current word completes; the next word starts only when out_en is high at a boundary.
- Parity enabled; word 0x07 → 8 data beats followed by parity beat 1; word 0x03 → parity beat 0.
- rst_n low during beat 3 → ser_valid=0 and empty=1 immediately; the first push after release serializes correctly.

Source files
------------

// File: rtl/fifo_serializer_pkg.sv
// Shared types and elaboration helpers for fifo_serializer.
package fifo_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    function automatic int beats(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth, input int lane_w);
        return (lane_w >= 1) && (data_w >= lane_w) && ((data_w % lane_w) == 0) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_serializer_buf.sv
// Word storage for fifo_serializer: circular array with wrap-bit pointers and registered status.
module fifo_serializer_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_req,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_s;
    logic              pop_s;

    // Pointer advance and status derived from the next pointers so flags track each edge.
    always_comb begin
        push_s   = wr_req && !full_q;
        pop_s    = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        level_d = wr_ptr_d - rd_ptr_d;
    end

    // Pointer and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/fifo_serializer.sv
// Word FIFO feeding a parallel-to-serial lane stage with start-of-word marker.
// Optional even-parity trailer beat: define FIFO_SERIALIZER_PARITY_EN.
module fifo_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int LANE_W    = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     out_en,
    output logic [LANE_W-1:0]        ser_data,
    output logic                     ser_valid,
    output logic                     ser_sof,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int BEATS = beats(DATA_W, LANE_W);
    localparam int BCW   = cnt_w(BEATS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [BCW-1:0] BEAT_ONE  = BCW'(1);

    if (!params_ok(DATA_W, DEPTH, LANE_W)) begin : g_bad_params
        $error("fifo_serializer: illegal DATA_W/DEPTH/LANE_W combination");
    end

    state_t              state_q, state_d;
    logic [BCW-1:0]      beat_q, beat_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [LANE_W-1:0]   ser_data_q, ser_data_d;
    logic                ser_valid_q, ser_valid_d;
    logic                ser_sof_q, ser_sof_d;
    logic [DATA_W-1:0]   head_s;
    logic                empty_s;
    logic                full_s;
    logic                pop_s;
    logic                boundary_s;

    fifo_serializer_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (in_data),
        .wr_req  (in_valid),
        .pop     (pop_s),
        .head    (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level)
    );

    // Beat b in transmit order; lane k counts from the least significant end.
    function automatic logic [LANE_W-1:0] lane_at(input logic [DATA_W-1:0] w, input logic [BCW-1:0] b);
        logic [BCW-1:0] k;
        k = (MSB_FIRST != 0) ? (LAST_BEAT - b) : b;
        return w[k*LANE_W +: LANE_W];
    endfunction

    // Serializer FSM: boundary_s marks the cycles where out_en may start the next word.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        word_d      = word_q;
        ser_data_d  = ser_data_q;
        ser_valid_d = ser_valid_q;
        ser_sof_d   = 1'b0;
        pop_s       = 1'b0;
        boundary_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                boundary_s = 1'b1;
            end
            ST_SHIFT: begin
                if (beat_q == LAST_BEAT) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
                    state_d     = ST_PAR;
                    ser_data_d  = LANE_W'(^word_q);
                    ser_valid_d = 1'b1;
`else
                    boundary_s  = 1'b1;
`endif
                end else begin
                    beat_d      = beat_q + BEAT_ONE;
                    ser_data_d  = lane_at(word_q, beat_q + BEAT_ONE);
                    ser_valid_d = 1'b1;
                end
            end
            ST_PAR: begin
                boundary_s = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                ser_data_d  = '0;
                ser_valid_d = 1'b0;
            end
        endcase
        if (boundary_s) begin
            if (out_en && !empty_s) begin
                pop_s       = 1'b1;
                word_d      = head_s;
                beat_d      = '0;
                ser_data_d  = lane_at(head_s, '0);
                ser_valid_d = 1'b1;
                ser_sof_d   = 1'b1;
                state_d     = ST_SHIFT;
            end else begin
                state_d     = ST_IDLE;
                beat_d      = '0;
                ser_data_d  = '0;
                ser_valid_d = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // FSM, shift word and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            word_q      <= '0;
            ser_data_q  <= '0;
            ser_valid_q <= 1'b0;
            ser_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            word_q      <= word_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            ser_sof_q   <= ser_sof_d;
        end
    end

    assign in_ready  = !full_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign ser_data  = ser_data_q;
    assign ser_valid = ser_valid_q;
    assign ser_sof   = ser_sof_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer: default instance plus a 4-bit MSB-first instance, scoreboarded.
module tb_fifo_serializer;

`ifdef FIFO_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic [3:0] data;
        logic       sof;
    } beat_t;

    beat_t exp_a[$];
    beat_t exp_b[$];
    int    errors = 0;
    int    checks = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] in_data_a = 8'h00;
    logic       in_valid_a = 1'b0;
    logic       in_ready_a;
    logic       out_en_a = 1'b0;
    logic [0:0] ser_data_a;
    logic       ser_valid_a, ser_sof_a, full_a, empty_a;
    logic [5:0] level_a;

    logic [7:0] in_data_b = 8'h00;
    logic       in_valid_b = 1'b0;
    logic       in_ready_b;
    logic       out_en_b = 1'b0;
    logic [3:0] ser_data_b;
    logic       ser_valid_b, ser_sof_b, full_b, empty_b;
    logic [2:0] level_b;

    fifo_serializer u_dut_a (
        .clk (clk), .rst_n (rst_n),
        .in_data (in_data_a), .in_valid (in_valid_a), .in_ready (in_ready_a),
        .out_en (out_en_a), .ser_data (ser_data_a), .ser_valid (ser_valid_a), .ser_sof (ser_sof_a),
        .full (full_a), .empty (empty_a), .level (level_a)
    );

    fifo_serializer #(.DATA_W(8), .DEPTH(4), .LANE_W(4), .MSB_FIRST(1)) u_dut_b (
        .clk (clk), .rst_n (rst_n),
        .in_data (in_data_b), .in_valid (in_valid_b), .in_ready (in_ready_b),
        .out_en (out_en_b), .ser_data (ser_data_b), .ser_valid (ser_valid_b), .ser_sof (ser_sof_b),
        .full (full_b), .empty (empty_b), .level (level_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic enq_a(input logic [7:0] w);
        beat_t b;
        for (int k = 0; k < 8; k++) begin
            b.data = {3'b000, w[k]};
            b.sof  = (k == 0);
            exp_a.push_back(b);
        end
        if (PAR != 0) begin
            b.data = {3'b000, ^w};
            b.sof  = 1'b0;
            exp_a.push_back(b);
        end
    endtask

    task automatic enq_b(input logic [7:0] w);
        beat_t b;
        b.data = w[7:4]; b.sof = 1'b1; exp_b.push_back(b);
        b.data = w[3:0]; b.sof = 1'b0; exp_b.push_back(b);
        if (PAR != 0) begin
            b.data = {3'b000, ^w};
            b.sof  = 1'b0;
            exp_b.push_back(b);
        end
    endtask

    // One clock, then compare any beat presented by either instance against its queue.
    task automatic tick();
        beat_t e;
        @(posedge clk);
        #1;
        if (ser_valid_a) begin
            check("a_beat_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                check("a_data", 32'(ser_data_a), 32'(e.data));
                check("a_sof", 32'(ser_sof_a), 32'(e.sof));
            end
        end else begin
            check("a_idle_sof", 32'(ser_sof_a), 32'd0);
            check("a_idle_data", 32'(ser_data_a), 32'd0);
        end
        if (ser_valid_b) begin
            check("b_beat_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                check("b_data", 32'(ser_data_b), 32'(e.data));
                check("b_sof", 32'(ser_sof_b), 32'(e.sof));
            end
        end else begin
            check("b_idle_sof", 32'(ser_sof_b), 32'd0);
        end
    endtask

    task automatic push_a(input logic [7:0] w);
        logic acc;
        in_data_a  = w;
        in_valid_a = 1'b1;
        acc        = in_ready_a;
        tick();
        in_valid_a = 1'b0;
        if (acc) enq_a(w);
    endtask

    task automatic push_b(input logic [7:0] w);
        logic acc;
        in_data_b  = w;
        in_valid_b = 1'b1;
        acc        = in_ready_b;
        tick();
        in_valid_b = 1'b0;
        if (acc) enq_b(w);
    endtask

    task automatic drain_a(input int bound);
        for (int i = 0; i < bound && exp_a.size() != 0; i++) tick();
        check("a_drain_done", 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ser_valid", 32'(ser_valid_a), 32'd0);
        check("rst_ser_data", 32'(ser_data_a), 32'd0);
        check("rst_ser_sof", 32'(ser_sof_a), 32'd0);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_empty", 32'(empty_a), 32'd1);
        check("rst_level", 32'(level_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_empty_b", 32'(empty_b), 32'd1);

        // 0xA5 LSB-first on consecutive cycles
        out_en_a = 1'b1;
        push_a(8'hA5);
        for (int i = 0; i < 4 && !ser_valid_a; i++) tick();
        check("a5_start", 32'(ser_valid_a), 32'd1);
        for (int i = 1; i < 8 + PAR; i++) begin
            tick();
            check("a5_consecutive", 32'(ser_valid_a), 32'd1);
        end
        tick();
        check("a5_end_valid", 32'(ser_valid_a), 32'd0);
        check("a5_end_empty", 32'(empty_a), 32'd1);
        check("a5_queue", 32'(exp_a.size()), 32'd0);

        // Nibble lanes, MSB first, back-to-back words
        push_b(8'h3C);
        push_b(8'h81);
        check("b_level2", 32'(level_b), 32'd2);
        out_en_b = 1'b1;
        for (int i = 0; i < 4 && !ser_valid_b; i++) tick();
        check("b_start", 32'(ser_valid_b), 32'd1);
        for (int i = 1; i < 2 * (2 + PAR); i++) begin
            tick();
            check("b_no_gap", 32'(ser_valid_b), 32'd1);
        end
        tick();
        check("b_end_valid", 32'(ser_valid_b), 32'd0);
        check("b_queue", 32'(exp_b.size()), 32'd0);

        // Fill across the pointer wrap, refuse overflow, drain in order
        out_en_a = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) push_a(8'($urandom_range(0, 255)));
        check("fill_full", 32'(full_a), 32'd1);
        check("fill_level", 32'(level_a), 32'd32);
        check("fill_in_ready", 32'(in_ready_a), 32'd0);
        push_a(8'hEE);
        check("overflow_level", 32'(level_a), 32'd32);
        check("overflow_full", 32'(full_a), 32'd1);
        out_en_a = 1'b1;
        tick();
        check("first_pop_level", 32'(level_a), 32'd31);
        check("first_pop_ready", 32'(in_ready_a), 32'd1);
        drain_a(32 * (8 + PAR) + 20);
        tick();
        check("drain_empty", 32'(empty_a), 32'd1);
        check("drain_level", 32'(level_a), 32'd0);

        // out_en pulse: only one word leaves, mid-word deassertion does not truncate
        out_en_a = 1'b0;
        push_a(8'h96);
        push_a(8'h3B);
        out_en_a = 1'b1;
        tick();
        out_en_a = 1'b0;
        repeat (8 + PAR + 6) tick();
        check("pulse_remaining", 32'(exp_a.size()), 32'(8 + PAR));
        check("pulse_level", 32'(level_a), 32'd1);
        check("pulse_idle", 32'(ser_valid_a), 32'd0);
        out_en_a = 1'b1;
        drain_a(40);

        // Parity words; second push coincides with the first load
        push_a(8'h07);
        push_a(8'h03);
        check("simul_push_pop_level", 32'(level_a), 32'd1);
        drain_a(40);

        // Reset in the middle of a word
        push_a(8'hC3);
        for (int i = 0; i < 4 && !ser_valid_a; i++) tick();
        repeat (3) tick();
        check("pre_reset_valid", 32'(ser_valid_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_valid", 32'(ser_valid_a), 32'd0);
        check("mid_reset_empty", 32'(empty_a), 32'd1);
        check("mid_reset_level", 32'(level_a), 32'd0);
        check("mid_reset_data", 32'(ser_data_a), 32'd0);
        exp_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push_a(8'h5A);
        drain_a(40);
        tick();
        check("post_reset_idle", 32'(ser_valid_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
